// File: rtl/sc_tx_pkg.sv
// Shared types and default sizes for the Schmidl-Cox TX framer and the RX-side blocks.
package sc_tx_pkg;

  localparam int unsigned SC_HALF_FFT_SIZE = 512;
  localparam int unsigned SC_CP_SIZE       = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CP      = 3'd1,
    PRE1    = 3'd2,
    PRE2    = 3'd3,
    PAYLOAD = 3'd4
  } sc_tx_state_e;

endpackage

// File: rtl/sc_preamble_inserter_if.sv
// Payload-in / framed-out sample streams of the preamble inserter.
interface sc_preamble_inserter_if;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  // master: the framer itself (sinks payload, sources the framed stream)
  modport master (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  // slave: the surrounding sample source and DAC-side sink
  modport slave (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/sc_preamble_ram.sv
// Half-symbol preamble store: one write port, one registered read port, no reset on contents.
module sc_preamble_ram #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [DEPTH];

  // Same-address write bypass lets a frame starting in the write cycle see the new word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/sc_preamble_inserter.sv
// TX framer: cyclic prefix + two identical preamble halves, then packet_length payload beats.
module sc_preamble_inserter
  import sc_tx_pkg::*;
#(
  parameter int unsigned HALF_FFT_SIZE = SC_HALF_FFT_SIZE,
  parameter int unsigned CP_SIZE       = SC_CP_SIZE
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [31:0]                      packet_length,
  input  logic                             cfg_wr_en,
  input  logic [$clog2(HALF_FFT_SIZE)-1:0] cfg_wr_addr,
  input  logic [31:0]                      cfg_wr_data,
  output logic                             cfg_wr_drop,
  sc_preamble_inserter_if.master           axis
);

  localparam int unsigned      AW        = $clog2(HALF_FFT_SIZE);
  localparam logic [AW-1:0]    CP_BASE   = AW'(HALF_FFT_SIZE - CP_SIZE);
  localparam logic [31:0]      CP_LAST   = 32'(CP_SIZE - 1);
  localparam logic [31:0]      HALF_LAST = 32'(HALF_FFT_SIZE - 1);

  sc_tx_state_e state_q, state_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  len_q, len_d;

  logic          rst_any;
  logic          pop;
  logic [2:0]    occ;
  logic          issue_ok;
  logic          issue, iss_last, iss_ram;
  logic [AW-1:0] rd_addr;
  logic [31:0]   ram_rdata;
  logic          ram_we;

  // stage 1 aligns payload beats with the 1-cycle RAM read
  logic          s1_valid, s1_last, s1_ram;
  logic [31:0]   s1_data;
  logic [32:0]   push_word;

  // 2-entry output skid: {last, data}
  logic [1:0]    fifo_cnt;
  logic [32:0]   e0, e1;

  assign rst_any = !reset_n || clear;
  assign pop     = axis.o_tvalid && axis.o_tready;
  // Issue only while stage-1 plus skid occupancy stays within two after this cycle's pop.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, s1_valid} - {2'b00, pop};
  assign issue_ok = !rst_any && (!axis.o_tvalid || axis.o_tready) && (occ < 3'd2);
  assign ram_we   = cfg_wr_en && (state_q == IDLE);

  sc_preamble_ram #(
    .DEPTH (HALF_FFT_SIZE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // The first CP read is issued in the IDLE cycle that starts the frame, so CP resumes at count 1.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    len_d         = len_q;
    issue         = 1'b0;
    iss_last      = 1'b0;
    iss_ram       = 1'b1;
    rd_addr       = CP_BASE + count_q[AW-1:0];
    axis.i_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (axis.i_tvalid && issue_ok) begin
          issue = 1'b1;
          len_d = packet_length;
          if (CP_SIZE == 1) begin
            state_d = PRE1;
            count_d = '0;
          end else begin
            state_d = CP;
            count_d = 32'd1;
          end
        end
      end
      CP: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (count_q == CP_LAST) begin
            state_d = PRE1;
            count_d = '0;
          end else begin
            count_d = count_q + 32'd1;
          end
        end
      end
      PRE1, PRE2: begin
        rd_addr = count_q[AW-1:0];
        if (issue_ok) begin
          issue = 1'b1;
          if (count_q == HALF_LAST) begin
            count_d = '0;
            if (state_q == PRE1) begin
              state_d = PRE2;
            end else if (len_q == '0) begin
              iss_last = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            count_d = count_q + 32'd1;
          end
        end
      end
      PAYLOAD: begin
        iss_ram       = 1'b0;
        axis.i_tready = issue_ok;
        if (issue_ok && axis.i_tvalid) begin
          issue = 1'b1;
          if (axis.i_tlast || (count_q == len_q - 32'd1)) begin
            iss_last = 1'b1;
            state_d  = IDLE;
            count_d  = '0;
          end else begin
            count_d = count_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_word = {s1_last, s1_ram ? ram_rdata : s1_data};

  always_ff @(posedge clk) begin
    if (rst_any) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_ram      <= 1'b0;
      s1_data     <= '0;
      fifo_cnt    <= '0;
      e0          <= '0;
      e1          <= '0;
      cfg_wr_drop <= 1'b0;
    end else begin
      cfg_wr_drop <= cfg_wr_en && (state_q != IDLE);
      s1_valid    <= issue;
      if (issue) begin
        s1_last <= iss_last;
        s1_ram  <= iss_ram;
        s1_data <= axis.i_tdata;
      end
      if (s1_valid && !pop) begin
        if (fifo_cnt == 2'd0) e0 <= push_word;
        else                  e1 <= push_word;
        fifo_cnt <= fifo_cnt + 2'd1;
      end else if (!s1_valid && pop) begin
        e0       <= e1;
        fifo_cnt <= fifo_cnt - 2'd1;
      end else if (s1_valid && pop) begin
        if (fifo_cnt == 2'd1) begin
          e0 <= push_word;
        end else begin
          e0 <= e1;
          e1 <= push_word;
        end
      end
    end
  end

  assign axis.o_tvalid = (fifo_cnt != 2'd0);
  assign axis.o_tdata  = e0[31:0];
  assign axis.o_tlast  = e0[32];

endmodule
